// File: rtl/counter191_sequencer_if.sv
// Requester-side job bus of the counter191 sequencer: job requests in,
// grants, completion pulses and results out.
interface counter191_sequencer_if #(
  parameter int STEPS_W = 8
);
  logic [1:0]         REQ;
  logic [3:0]         REQ_D0;
  logic [3:0]         REQ_D1;
  logic [1:0]         REQ_DIR;
  logic [STEPS_W-1:0] REQ_STEPS0;
  logic [STEPS_W-1:0] REQ_STEPS1;
  logic [1:0]         GNT;
  logic               BUSY;
  logic [1:0]         DONE;
  logic [3:0]         RESULT;
  logic               WRAP;

  modport master (
    output REQ, REQ_D0, REQ_D1, REQ_DIR, REQ_STEPS0, REQ_STEPS1,
    input  GNT, BUSY, DONE, RESULT, WRAP
  );

  modport slave (
    input  REQ, REQ_D0, REQ_D1, REQ_DIR, REQ_STEPS0, REQ_STEPS1,
    output GNT, BUSY, DONE, RESULT, WRAP
  );
endinterface

// File: rtl/counter191_sequencer.sv
// Two-requester job sequencer driving a shared 74LS191-style counter.
// Define COUNTER191_FIXED_PRIORITY_EN for fixed priority (requester 0 wins ties).
module counter191_sequencer #(
  parameter int STEPS_W = 8
) (
  input  logic                   CLK,
  input  logic                   RESET_n,
  counter191_sequencer_if.slave  bus,
  output logic [3:0]             CNT_D,
  output logic                   CNT_LOAD_n,
  output logic                   CNT_CTEN_n,
  output logic                   CNT_DOWN_UP_n,
  input  logic [3:0]             CNT_Q,
  input  logic                   CNT_RCO_n
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, FINISH} state_t;

  state_t             state_reg;
  logic [1:0]         gnt_reg;
  logic [1:0]         done_reg;
  logic               busy_reg;
  logic [3:0]         result_reg;
  logic               wrap_reg;
  logic               wrap_flag_reg;
  logic [3:0]         cnt_d_reg;
  logic               cnt_load_n_reg;
  logic               cnt_cten_n_reg;
  logic               cnt_down_up_n_reg;
  logic [STEPS_W-1:0] steps_reg;
  logic [STEPS_W-1:0] remaining_reg;
`ifndef COUNTER191_FIXED_PRIORITY_EN
  logic               last_reg;
`endif

  logic [3:0]         req_d     [2];
  logic [STEPS_W-1:0] req_steps [2];
  logic [1:0]         req_live;
  logic               pick_valid;
  logic               pick;

  assign req_d[0]     = bus.REQ_D0;
  assign req_d[1]     = bus.REQ_D1;
  assign req_steps[0] = bus.REQ_STEPS0;
  assign req_steps[1] = bus.REQ_STEPS1;

  // A requester that just finished is ignored while its DONE is high.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_live[gi] = bus.REQ[gi] & ~done_reg[gi];
    end
  endgenerate

  always_comb begin
    pick_valid = |req_live;
    pick       = 1'b0;
`ifdef COUNTER191_FIXED_PRIORITY_EN
    pick = ~req_live[0];
`else
    if (req_live == 2'b11) begin
      pick = ~last_reg;
    end else begin
      pick = ~req_live[0];
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg         <= IDLE;
      gnt_reg           <= 2'b00;
      done_reg          <= 2'b00;
      busy_reg          <= 1'b0;
      result_reg        <= 4'd0;
      wrap_reg          <= 1'b0;
      wrap_flag_reg     <= 1'b0;
      cnt_d_reg         <= 4'd0;
      cnt_load_n_reg    <= 1'b1;
      cnt_cten_n_reg    <= 1'b1;
      cnt_down_up_n_reg <= 1'b0;
      steps_reg         <= '0;
      remaining_reg     <= '0;
`ifndef COUNTER191_FIXED_PRIORITY_EN
      last_reg          <= 1'b1;
`endif
    end else begin
      done_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gnt_reg           <= pick ? 2'b10 : 2'b01;
            busy_reg          <= 1'b1;
            cnt_d_reg         <= req_d[pick];
            cnt_down_up_n_reg <= bus.REQ_DIR[pick];
            steps_reg         <= req_steps[pick];
            cnt_load_n_reg    <= 1'b0;
            state_reg         <= LOAD;
`ifndef COUNTER191_FIXED_PRIORITY_EN
            last_reg          <= pick;
`endif
          end
        end
        LOAD: begin
          cnt_load_n_reg <= 1'b1;
          wrap_flag_reg  <= 1'b0;
          if (steps_reg == '0) begin
            state_reg <= FINISH;
          end else begin
            remaining_reg  <= steps_reg;
            cnt_cten_n_reg <= 1'b0;
            state_reg      <= COUNT;
          end
        end
        COUNT: begin
          // RCO low while enabled means the counter sits at its terminal count.
          if (!CNT_RCO_n) begin
            wrap_flag_reg <= 1'b1;
          end
          remaining_reg <= remaining_reg - 1'b1;
          if (remaining_reg == STEPS_W'(1)) begin
            cnt_cten_n_reg <= 1'b1;
            state_reg      <= FINISH;
          end
        end
        FINISH: begin
          result_reg <= CNT_Q;
          wrap_reg   <= wrap_flag_reg;
          done_reg   <= gnt_reg;
          gnt_reg    <= 2'b00;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.GNT       = gnt_reg;
  assign bus.BUSY      = busy_reg;
  assign bus.DONE      = done_reg;
  assign bus.RESULT    = result_reg;
  assign bus.WRAP      = wrap_reg;
  assign CNT_D         = cnt_d_reg;
  assign CNT_LOAD_n    = cnt_load_n_reg;
  assign CNT_CTEN_n    = cnt_cten_n_reg;
  assign CNT_DOWN_UP_n = cnt_down_up_n_reg;

endmodule

// File: tb/tb_counter191_sequencer.sv
// Scoreboard bench for counter191_sequencer with a behavioural 74LS191 model.
module tb_counter191_sequencer;
  localparam int STEPS_W = 8;

  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  logic [3:0] CNT_D;
  logic CNT_LOAD_n, CNT_CTEN_n, CNT_DOWN_UP_n;
  logic [3:0] CNT_Q;
  logic CNT_RCO_n;

  logic req0 = 1'b0, req1 = 1'b0, dir0 = 1'b0, dir1 = 1'b0;
  logic [3:0] d0 = 4'd0, d1 = 4'd0;
  logic [STEPS_W-1:0] steps0 = '0, steps1 = '0;

  counter191_sequencer_if #(.STEPS_W(STEPS_W)) bus ();
  assign bus.REQ        = {req1, req0};
  assign bus.REQ_DIR    = {dir1, dir0};
  assign bus.REQ_D0     = d0;
  assign bus.REQ_D1     = d1;
  assign bus.REQ_STEPS0 = steps0;
  assign bus.REQ_STEPS1 = steps1;

  counter191_sequencer #(.STEPS_W(STEPS_W)) dut (
    .CLK           (CLK),
    .RESET_n       (RESET_n),
    .bus           (bus),
    .CNT_D         (CNT_D),
    .CNT_LOAD_n    (CNT_LOAD_n),
    .CNT_CTEN_n    (CNT_CTEN_n),
    .CNT_DOWN_UP_n (CNT_DOWN_UP_n),
    .CNT_Q         (CNT_Q),
    .CNT_RCO_n     (CNT_RCO_n)
  );

  always #5 CLK = ~CLK;

  // Counter: synchronous load, enabled count, never reset.
  logic [3:0] q_model = 4'd0;
  always @(posedge CLK) begin
    if (CNT_LOAD_n == 1'b0) q_model <= CNT_D;
    else if (CNT_CTEN_n == 1'b0) q_model <= CNT_DOWN_UP_n ? q_model - 4'd1 : q_model + 4'd1;
  end
  assign CNT_Q     = q_model;
  assign CNT_RCO_n = !((CNT_CTEN_n == 1'b0) && (CNT_DOWN_UP_n ? (q_model == 4'd0) : (q_model == 4'd15)));

  typedef struct {
    int d;
    int dir;
    int steps;
    int result;
    int wrap;
  } job_t;

  job_t exp_q0[$];
  job_t exp_q1[$];
  int   grant_log[$];
  int   checks = 0;
  int   failures = 0;
  int   issued = 0;
  int   completed = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic job_t make_job(input int d, input int dir, input int steps);
    job_t j;
    j.d = d;
    j.dir = dir;
    j.steps = steps;
    if (dir == 0) begin
      j.result = (d + steps) % 16;
      j.wrap   = (d + steps > 15) ? 1 : 0;
    end else begin
      j.result = (d - (steps % 16) + 16) % 16;
      j.wrap   = (steps > d) ? 1 : 0;
    end
    return j;
  endfunction

  // Raise a job on one requester, wait for its DONE, drop REQ in the DONE cycle.
  task automatic issue(input int id, input int d, input int dir, input int steps);
    job_t j;
    int   n;
    bit   seen;
    j = make_job(d, dir, steps);
    issued++;
    if (id == 0) begin
      d0 = 4'(d); dir0 = 1'(dir); steps0 = STEPS_W'(steps);
      exp_q0.push_back(j);
      req0 = 1'b1;
    end else begin
      d1 = 4'(d); dir1 = 1'(dir); steps1 = STEPS_W'(steps);
      exp_q1.push_back(j);
      req1 = 1'b1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < steps + 600) begin
      @(negedge CLK);
      if (bus.DONE[id]) seen = 1'b1;
      n++;
    end
    chk("done_timeout", int'(seen), 1);
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // Monitor: tracks accept, counts enabled edges, checks each completion.
  int         cyc = 0;
  logic [1:0] prev_gnt = 2'b00;
  bit         active = 1'b0;
  int         acc_cyc = 0;
  int         gid = 0;
  int         cten_cnt = 0;
  job_t       cur;

  always begin
    @(posedge CLK);
    #1;
    cyc++;
    if (!RESET_n) begin
      active = 1'b0;
      prev_gnt = 2'b00;
    end else begin
      if (bus.GNT != 2'b00 && prev_gnt == 2'b00) begin
        gid = int'(bus.GNT[1]);
        grant_log.push_back(gid);
        chk("gnt_onehot", $countones(bus.GNT), 1);
        chk("busy_on_accept", int'(bus.BUSY), 1);
        if ((gid == 0 && exp_q0.size() == 0) || (gid == 1 && exp_q1.size() == 0)) begin
          chk("unexpected_grant", gid + 10, -1);
          active = 1'b0;
        end else begin
          cur = (gid == 0) ? exp_q0[0] : exp_q1[0];
          active = 1'b1;
          acc_cyc = cyc;
          cten_cnt = 0;
          chk("load_n_in_load", int'(CNT_LOAD_n), 0);
          chk("cnt_d_in_load", int'(CNT_D), cur.d);
          chk("dir_in_load", int'(CNT_DOWN_UP_n), cur.dir);
        end
      end else if (active && CNT_CTEN_n == 1'b0) begin
        cten_cnt++;
      end
      if (bus.DONE != 2'b00) begin
        if (!active) begin
          chk("unexpected_done", int'(bus.DONE), 0);
        end else begin
          chk("done_onehot", int'(bus.DONE), 1 << gid);
          chk("result", int'(bus.RESULT), cur.result);
          chk("wrap", int'(bus.WRAP), cur.wrap);
          chk("done_latency", cyc - acc_cyc, cur.steps + 2);
          chk("enabled_edges", cten_cnt, cur.steps);
          chk("gnt_low_at_done", int'(bus.GNT), 0);
          chk("busy_low_at_done", int'(bus.BUSY), 0);
          chk("dir_held", int'(CNT_DOWN_UP_n), cur.dir);
          if (gid == 0) void'(exp_q0.pop_front());
          else void'(exp_q1.pop_front());
          completed++;
          active = 1'b0;
        end
      end
      prev_gnt = bus.GNT;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_gnt"}, int'(bus.GNT), 0);
    chk({tag, "_done"}, int'(bus.DONE), 0);
    chk({tag, "_busy"}, int'(bus.BUSY), 0);
    chk({tag, "_result"}, int'(bus.RESULT), 0);
    chk({tag, "_wrap"}, int'(bus.WRAP), 0);
    chk({tag, "_load_n"}, int'(CNT_LOAD_n), 1);
    chk({tag, "_cten_n"}, int'(CNT_CTEN_n), 1);
    chk({tag, "_down_up_n"}, int'(CNT_DOWN_UP_n), 0);
    chk({tag, "_cnt_d"}, int'(CNT_D), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog_expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   last_served;
    int   first;
    int   n;
    int   q_frozen;
    int   mode;
    job_t j;

    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    RESET_n = 1'b1;
    @(negedge CLK);

    issue(0, 5, 0, 5);   @(negedge CLK);
    issue(1, 13, 0, 4);  @(negedge CLK);
    issue(0, 2, 1, 3);   @(negedge CLK);
    chk("dir_hold_idle", int'(CNT_DOWN_UP_n), 1);
    issue(0, 8, 0, 0);   @(negedge CLK);
    last_served = 0;

    // Both requesters contend; each re-raises the cycle after its DONE.
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          issue(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1);
          @(negedge CLK);
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          issue(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1);
          @(negedge CLK);
        end
      end
    join
    first = 1 - last_served;
    chk("alt_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      chk("alt_grant_order", grant_log[k], (k % 2 == 0) ? first : 1 - first);
    end

    // Reset in the middle of a 10-step up count from 0000.
    j = make_job(0, 0, 10);
    exp_q0.push_back(j);
    d0 = 4'd0; dir0 = 1'b0; steps0 = STEPS_W'(10); req0 = 1'b1;
    n = 0;
    while (!bus.GNT[0] && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("midjob_accept", int'(bus.GNT[0]), 1);
    repeat (4) @(negedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    check_reset_values("midjob_reset");
    q_frozen = int'(CNT_Q);
    chk("q_partial", q_frozen, 3);
    req0 = 1'b0;
    exp_q0.delete();
    repeat (3) @(negedge CLK);
    chk("q_frozen", int'(CNT_Q), q_frozen);
    RESET_n = 1'b1;
    @(negedge CLK);

    // After reset requester 0 wins a tie.
    grant_log.delete();
    fork
      issue(0, 9, 1, 2);
      issue(1, 4, 0, 2);
    join
    @(negedge CLK);
    chk("post_reset_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("post_reset_first", grant_log[0], 0);
      chk("post_reset_second", grant_log[1], 1);
    end

    for (int it = 0; it < 25; it++) begin
      int sa, sb;
      mode = int'($urandom_range(0, 2));
      sa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      sb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      if (mode == 0) begin
        issue(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), sa);
      end else if (mode == 1) begin
        issue(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), sb);
      end else begin
        fork
          issue(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), sa);
          issue(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), sb);
        join
      end
      @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    chk("queues_drained", exp_q0.size() + exp_q1.size(), 0);
    chk("jobs_completed", completed, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
